// File: rtl/pwm_peripheral_pkg.sv
// Shared constants for the PWM peripheral and its timebase.
// Holds counter/pin widths, the full-duty code and the default clock divider.
package pwm_peripheral_pkg;

    localparam int PWM_CNT_W = 8;
    localparam int NUM_PINS = 16;
    localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;

    // 10 MHz / (13 * 256) gives roughly a 3.0 kHz PWM period.
    localparam int CLK_DIV_DEFAULT = 13;

    // Prescaler width; a divider of 1 still needs a one-bit register.
    function automatic int pre_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler, 8-bit period counter, double-buffered duty.
// Ports: clk, rst_n, duty_i (requested duty), pwm_raw_o, period_start_o.
module pwm_timebase
    import pwm_peripheral_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PWM_CNT_W-1:0] duty_i,
    output logic                 pwm_raw_o,
    output logic                 period_start_o
);

    localparam int PRE_W = pre_width(CLK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0]     pre_q, pre_d;
    logic [PWM_CNT_W-1:0] cnt_q, cnt_d;
    logic [PWM_CNT_W-1:0] shadow_q, shadow_d;
    logic                 ps_q, ps_d;
    logic                 tick;
    logic                 wrap;

    assign tick = (pre_q == PRE_LAST);
    assign wrap = tick && (cnt_q == '1);

    // Duty is only latched on the period boundary so the waveform
    // never sees a partial period.
    always_comb begin
        pre_d    = tick ? '0 : pre_q + 1'b1;
        cnt_d    = tick ? cnt_q + 1'b1 : cnt_q;
        shadow_d = wrap ? duty_i : shadow_q;
        ps_d     = wrap;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q    <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            ps_q     <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            ps_q     <= ps_d;
        end
    end

    // Full-scale duty is special-cased so 0xFF has no low step at 255.
    assign pwm_raw_o = (shadow_q == DUTY_FULL) || (cnt_q < shadow_q);
    assign period_start_o = ps_q;

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin PWM output block driven from the SPI register file.
// Ports: clk, rst_n, enable/mode/duty registers in, out_7_0/out_15_8, period_start.
module pwm_peripheral
    import pwm_peripheral_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] en_reg_out_7_0,
    input  logic [7:0] en_reg_out_15_8,
    input  logic [7:0] en_reg_pwm_7_0,
    input  logic [7:0] en_reg_pwm_15_8,
    input  logic [7:0] pwm_duty_cycle,
    output logic [7:0] out_7_0,
    output logic [7:0] out_15_8,
    output logic       period_start
);

    logic [NUM_PINS-1:0] en;
    logic [NUM_PINS-1:0] pm;
    logic [NUM_PINS-1:0] out_q, out_d;
    logic                pwm_raw;

    pwm_timebase #(
        .CLK_DIV(CLK_DIV)
    ) u_timebase (
        .clk           (clk),
        .rst_n         (rst_n),
        .duty_i        (pwm_duty_cycle),
        .pwm_raw_o     (pwm_raw),
        .period_start_o(period_start)
    );

    assign en = {en_reg_out_15_8, en_reg_out_7_0};
    assign pm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // Disabled pins are low; enabled pins are static high unless in
    // PWM mode, where all share the same phase-aligned waveform.
    always_comb begin
        out_d = en & (~pm | {NUM_PINS{pwm_raw}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out_7_0  = out_q[7:0];
    assign out_15_8 = out_q[15:8];

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral.
// A cycle model feeds a scoreboard queue; scenario tasks add directed checks.
module tb_pwm_peripheral;

    localparam int CLK_DIV = 13;
    localparam int PERIOD = CLK_DIV * 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] en_lo = '0, en_hi = '0, pm_lo = '0, pm_hi = '0;
    logic [7:0] duty = '0;
    logic [7:0] out_7_0, out_15_8;
    logic       period_start;

    int checks = 0;
    int errors = 0;
    int fail_prints = 0;

    pwm_peripheral #(
        .CLK_DIV(CLK_DIV)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en_reg_out_7_0 (en_lo),
        .en_reg_out_15_8(en_hi),
        .en_reg_pwm_7_0 (pm_lo),
        .en_reg_pwm_15_8(pm_hi),
        .pwm_duty_cycle (duty),
        .out_7_0        (out_7_0),
        .out_15_8       (out_15_8),
        .period_start   (period_start)
    );

    always #50 clk = ~clk;

    typedef struct packed {
        logic [15:0] out;
        logic        ps;
    } exp_t;

    exp_t sbq[$];

    int         m_pre;
    int         m_cnt;
    int         m_sh;
    logic [15:0] m_out;
    logic       m_ps;
    logic       m_tick;
    logic       m_raw;
    logic [15:0] m_en, m_pm;

    // Reference model: pushes the expected registered outputs each edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pre = 0;
            m_cnt = 0;
            m_sh  = 0;
            m_out = '0;
            m_ps  = 1'b0;
            sbq.delete();
        end else begin
            m_en = {en_hi, en_lo};
            m_pm = {pm_hi, pm_lo};
            m_tick = (m_pre == CLK_DIV - 1);
            if (m_sh == 255) m_raw = 1'b1;
            else m_raw = (m_cnt < m_sh);
            for (int i = 0; i < 16; i++) begin
                if (!m_en[i]) m_out[i] = 1'b0;
                else if (m_pm[i]) m_out[i] = m_raw;
                else m_out[i] = 1'b1;
            end
            m_ps = m_tick && (m_cnt == 255);
            if (m_ps) m_sh = int'(duty);
            m_pre = m_tick ? 0 : m_pre + 1;
            if (m_tick) m_cnt = (m_cnt + 1) % 256;
            sbq.push_back('{out: m_out, ps: m_ps});
        end
    end

    // Scoreboard: one expected entry per clock while out of reset.
    exp_t e;
    always @(negedge clk) begin
        if (rst_n && sbq.size() != 0) begin
            e = sbq.pop_front();
            checks++;
            if ({out_15_8, out_7_0} !== e.out || period_start !== e.ps) begin
                errors++;
                if (fail_prints < 20) begin
                    fail_prints++;
                    $display("FAIL scoreboard t=%0t out=%h ps=%b expected out=%h ps=%b",
                             $time, {out_15_8, out_7_0}, period_start, e.out, e.ps);
                end
            end
        end
    end

    task automatic test_reset();
        en_lo = '0; en_hi = '0; pm_lo = '0; pm_hi = '0; duty = 8'h80;
        #10 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_15_8, out_7_0} !== 16'h0 || period_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_async out=%h ps=%b expected out=0000 ps=0",
                     {out_15_8, out_7_0}, period_start);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_15_8, out_7_0} !== 16'h0 || period_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold out=%h ps=%b expected out=0000 ps=0",
                     {out_15_8, out_7_0}, period_start);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_disabled();
        int nps = 0, last = -1, gap = 0, bad = 0;
        for (int k = 1; k <= 2 * PERIOD + 10; k++) begin
            @(negedge clk);
            if ({out_15_8, out_7_0} !== 16'h0) bad++;
            if (period_start === 1'b1) begin
                if (last >= 0) gap = k - last;
                if (last < 0 && k !== PERIOD) bad++;
                last = k;
                nps++;
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL disabled_out bad_cycles=%0d expected 0", bad);
        end
        checks++;
        if (nps !== 2) begin
            errors++;
            $display("FAIL disabled_ps_count got=%0d expected 2", nps);
        end
        checks++;
        if (gap !== PERIOD) begin
            errors++;
            $display("FAIL ps_spacing got=%0d expected %0d", gap, PERIOD);
        end
    endtask

    task automatic test_static();
        en_lo = 8'hFF; en_hi = 8'h00; pm_lo = '0; pm_hi = '0;
        #1;
        checks++;
        if (out_7_0 !== 8'h00) begin
            errors++;
            $display("FAIL static_early out_7_0=%h expected 00", out_7_0);
        end
        @(negedge clk);
        checks++;
        if (out_7_0 !== 8'hFF || out_15_8 !== 8'h00) begin
            errors++;
            $display("FAIL static_on out=%h expected 00ff", {out_15_8, out_7_0});
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_pwm50();
        int n = 0, hi = 0, psk = 0;
        en_lo = 8'h01; en_hi = '0; pm_lo = 8'h01; pm_hi = '0; duty = 8'h80;
        do begin
            @(negedge clk);
            n++;
        end while (period_start !== 1'b1 && n < PERIOD + 16);
        checks++;
        if (period_start !== 1'b1) begin
            errors++;
            $display("FAIL pwm50_wait_ps timeout after %0d cycles", n);
        end
        for (int k = 1; k <= PERIOD; k++) begin
            @(negedge clk);
            if (out_7_0[0] === 1'b1) hi++;
            if (period_start === 1'b1 && psk == 0) psk = k;
        end
        checks++;
        if (hi !== PERIOD / 2) begin
            errors++;
            $display("FAIL pwm50_high got=%0d expected %0d", hi, PERIOD / 2);
        end
        checks++;
        if (psk !== PERIOD) begin
            errors++;
            $display("FAIL pwm50_period got=%0d expected %0d", psk, PERIOD);
        end
    endtask

    task automatic test_extremes();
        int n = 0, hi0 = 0, hi1 = 0;
        duty = 8'h00;
        do begin
            @(negedge clk);
            n++;
        end while (period_start !== 1'b1 && n < PERIOD + 16);
        checks++;
        if (period_start !== 1'b1) begin
            errors++;
            $display("FAIL ext_wait_ps timeout after %0d cycles", n);
        end
        for (int k = 1; k <= PERIOD; k++) begin
            @(negedge clk);
            if (k == 1000) duty = 8'hFF;
            if (out_7_0[0] === 1'b1) hi0++;
        end
        for (int k = 1; k <= PERIOD; k++) begin
            @(negedge clk);
            if (out_7_0[0] === 1'b1) hi1++;
        end
        checks++;
        if (hi0 !== 0) begin
            errors++;
            $display("FAIL duty00_high got=%0d expected 0", hi0);
        end
        checks++;
        if (hi1 !== PERIOD) begin
            errors++;
            $display("FAIL dutyFF_high got=%0d expected %0d", hi1, PERIOD);
        end
    endtask

    task automatic test_mid_change();
        int n = 0, hi0 = 0, hi1 = 0;
        duty = 8'h40;
        do begin
            @(negedge clk);
            n++;
        end while (period_start !== 1'b1 && n < PERIOD + 16);
        checks++;
        if (period_start !== 1'b1) begin
            errors++;
            $display("FAIL mid_wait_ps timeout after %0d cycles", n);
        end
        for (int k = 1; k <= PERIOD; k++) begin
            @(negedge clk);
            if (k == 100 * CLK_DIV) duty = 8'hC0;
            if (out_7_0[0] === 1'b1) hi0++;
        end
        for (int k = 1; k <= PERIOD; k++) begin
            @(negedge clk);
            if (out_7_0[0] === 1'b1) hi1++;
        end
        checks++;
        if (hi0 !== 64 * CLK_DIV) begin
            errors++;
            $display("FAIL mid_old_high got=%0d expected %0d", hi0, 64 * CLK_DIV);
        end
        checks++;
        if (hi1 !== 192 * CLK_DIV) begin
            errors++;
            $display("FAIL mid_new_high got=%0d expected %0d", hi1, 192 * CLK_DIV);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0, pwm_hi = 0, st_hi = 0, psk = 0, hi = 0;
        en_lo = 8'hFF; en_hi = 8'hFF; pm_lo = 8'hFF; pm_hi = 8'h00;
        duty = 8'h80;
        do begin
            @(negedge clk);
            n++;
        end while (period_start !== 1'b1 && n < PERIOD + 16);
        checks++;
        if (period_start !== 1'b1) begin
            errors++;
            $display("FAIL rmid_wait_ps timeout after %0d cycles", n);
        end
        repeat (150 * CLK_DIV) @(negedge clk);
        checks++;
        if (out_15_8 !== 8'hFF) begin
            errors++;
            $display("FAIL rmid_pre out_15_8=%h expected ff", out_15_8);
        end
        #10 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_15_8, out_7_0} !== 16'h0 || period_start !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async out=%h ps=%b expected out=0000 ps=0",
                     {out_15_8, out_7_0}, period_start);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= PERIOD; k++) begin
            @(negedge clk);
            if (out_7_0 !== 8'h00) pwm_hi++;
            if (out_15_8 === 8'hFF) st_hi++;
            if (period_start === 1'b1 && psk == 0) psk = k;
        end
        for (int k = 1; k <= PERIOD; k++) begin
            @(negedge clk);
            if (out_7_0 === 8'hFF) hi++;
        end
        checks++;
        if (pwm_hi !== 0) begin
            errors++;
            $display("FAIL rmid_pwm_low got=%0d expected 0", pwm_hi);
        end
        checks++;
        if (st_hi !== PERIOD) begin
            errors++;
            $display("FAIL rmid_static got=%0d expected %0d", st_hi, PERIOD);
        end
        checks++;
        if (psk !== PERIOD) begin
            errors++;
            $display("FAIL rmid_first_ps got=%0d expected %0d", psk, PERIOD);
        end
        checks++;
        if (hi !== PERIOD / 2) begin
            errors++;
            $display("FAIL rmid_reload_high got=%0d expected %0d", hi, PERIOD / 2);
        end
    endtask

    initial begin
        test_reset();
        test_disabled();
        test_static();
        test_pwm50();
        test_extremes();
        test_mid_change();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
